// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer: captures a NIBBLES-digit hex word and streams it out as
// ASCII characters, most significant nibble first, one per ready/valid beat.
// Optional build macro HEX_ASCII_LZ_SUPPRESS_EN: when defined, leading zero
// nibbles are shown as spaces (the last digit is always a digit) so that
// values sit right-aligned in a fixed-width LCD field.
module hex_ascii_streamer #(
  parameter int NIBBLES   = 8,
  parameter int UPPERCASE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4*NIBBLES-1:0]   i_word,
  input  logic                   i_word_valid,
  output logic                   o_word_ready,
  output logic [7:0]             o_char,
  output logic                   o_char_valid,
  input  logic                   i_char_ready,
  output logic                   o_char_last,
  output logic                   o_busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // ST_INIT holds word_ready low for the single cycle after reset release
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_EMIT} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    shift_reg, shift_next;
  logic [IW-1:0]   index_reg, index_next;
  logic [7:0]      char_reg, char_next;
  logic            valid_reg, valid_next;
  logic            last_reg, last_next;
  logic            busy_reg, busy_next;

  // Character load path shared by word acceptance and the per-beat advance
  logic            load;
  logic [3:0]      load_nib;
  logic            load_final;

`ifdef HEX_ASCII_LZ_SUPPRESS_EN
  // Sticky: a non-zero digit has already been emitted for this word
  logic            seen_reg, seen_next;
  logic            load_seen;
`endif

  // Plain hex digit to ASCII, 8-bit arithmetic on the zero-extended nibble
  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    logic [7:0] z;
    z = {4'h0, nib};
    if (nib < 4'd10)
      return 8'h30 + z;
    else if (UPPERCASE != 0)
      return 8'h37 + z;
    else
      return 8'h57 + z;
  endfunction

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_INIT;
      shift_reg <= '0;
      index_reg <= '0;
      char_reg  <= 8'h00;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef HEX_ASCII_LZ_SUPPRESS_EN
      seen_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      index_reg <= index_next;
      char_reg  <= char_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
`ifdef HEX_ASCII_LZ_SUPPRESS_EN
      seen_reg  <= seen_next;
`endif
    end
  end

  // Next-state logic: accept a word, then advance one nibble per handshake
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    index_next = index_reg;
    char_next  = char_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    load       = 1'b0;
    load_nib   = 4'h0;
    load_final = 1'b0;
`ifdef HEX_ASCII_LZ_SUPPRESS_EN
    seen_next  = seen_reg;
    load_seen  = 1'b0;
`endif

    case (state_reg)
      ST_INIT: begin
        state_next = ST_IDLE;
      end

      ST_IDLE: begin
        if (i_word_valid) begin
          shift_next = i_word;
          index_next = IW'(NIBBLES - 1);
          valid_next = 1'b1;
          busy_next  = 1'b1;
          state_next = ST_EMIT;
          load       = 1'b1;
          load_nib   = i_word[W-1 -: 4];
          load_final = (NIBBLES == 1);
`ifdef HEX_ASCII_LZ_SUPPRESS_EN
          load_seen  = 1'b0;
`endif
        end
      end

      ST_EMIT: begin
        if (i_char_ready) begin
          if (index_reg == '0) begin
            // Final character taken: drop back to idle
            state_next = ST_IDLE;
            char_next  = 8'h00;
            valid_next = 1'b0;
            last_next  = 1'b0;
            busy_next  = 1'b0;
          end else begin
            shift_next = shift_reg << 4;
            index_next = index_reg - IW'(1);
            load       = 1'b1;
            load_nib   = shift_next[W-1 -: 4];
            load_final = (index_next == '0);
`ifdef HEX_ASCII_LZ_SUPPRESS_EN
            load_seen  = seen_reg;
`endif
          end
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase

    // Register the character for the nibble now at the top of the word
    if (load) begin
      last_next = load_final;
`ifdef HEX_ASCII_LZ_SUPPRESS_EN
      seen_next = load_seen | (load_nib != 4'h0);
      char_next = (load_seen || load_nib != 4'h0 || load_final) ?
                  to_ascii(load_nib) : 8'h20;
`else
      char_next = to_ascii(load_nib);
`endif
    end
  end

  assign o_word_ready = (state_reg == ST_IDLE);
  assign o_char       = char_reg;
  assign o_char_valid = valid_reg;
  assign o_char_last  = last_reg;
  assign o_busy       = busy_reg;

endmodule
